// File: rtl/decode_stage.sv
// Instruction decode: field split, 32x16 register file with writeback bypass,
// busy-bit scoreboard for RAW/WAW interlock, and the ID/EX pipeline register.
module decode_stage #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] npc_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_index,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic [4:0]        control_in_ex,
  output logic [4:0]        dest_index,
  output logic [DATA_W-1:0] reg1_data,
  output logic [DATA_W-1:0] reg2_data,
  output logic [DATA_W-1:0] npc,
  output logic [6:0]        immediate,
  output logic              ex_valid
);

  logic [DATA_W-1:0]   rf [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;
  logic [NUM_REGS-1:0] busy_eff;

  logic [4:0] opc;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] imm;
  logic       use1;
  logic       use2;
  logic       wr;
  logic       src_hz;
  logic       waw;
  logic       hazard;
  logic       issue;
  logic       unused_bits;

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  assign opc = instr[31:27];
  assign rd  = instr[26:22];
  assign rs1 = instr[21:17];
  assign rs2 = instr[16:12];
  assign imm = instr[6:0];
  assign unused_bits = ^instr[11:7];

  // 00000 is NOP, 00011 (ADDI) has no rs2, 1xxxx never writes rd
  assign use1 = |opc;
  assign use2 = |opc && (opc != 5'd3);
  assign wr   = |opc && !opc[4];

  assign clr = wb_en ? (NUM_REGS'(1) << wb_index) : '0;
  assign busy_eff = busy & ~clr;

  assign src_hz = (use1 && busy_eff[rs1]) ||
                  (use2 && busy_eff[rs2]);
  assign waw    = wr && busy[rd];
  assign hazard = instr_valid && !flush && (src_hz || waw);
  assign issue  = instr_valid && !flush && !hazard;
  assign stall_out = hazard;

  assign set = (issue && wr && (rd != 5'd0)) ?
               (NUM_REGS'(1) << rd) : '0;

  always_comb begin
    op1 = rf[rs1];
    if (rs1 == 5'd0)
      op1 = '0;
    else if (wb_en && (wb_index == rs1))
      op1 = wb_data;
  end

  always_comb begin
    op2 = rf[rs2];
    if (rs2 == 5'd0)
      op2 = '0;
    else if (wb_en && (wb_index == rs2))
      op2 = wb_data;
  end

  always_ff @(posedge clk) begin
    if (wb_en && (wb_index != 5'd0))
      rf[wb_index] <= wb_data;
  end

  // OR-ing set after the clear lets a same-cycle issue win
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy <= '0;
    else
      busy <= ((busy & ~clr) | set) & ~NUM_REGS'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control_in_ex <= '0;
      dest_index    <= '0;
      reg1_data     <= '0;
      reg2_data     <= '0;
      npc           <= '0;
      immediate     <= '0;
      ex_valid      <= 1'b0;
    end else if (flush || hazard || !instr_valid) begin
      control_in_ex <= '0;
      dest_index    <= '0;
      reg1_data     <= '0;
      reg2_data     <= '0;
      npc           <= '0;
      immediate     <= '0;
      ex_valid      <= 1'b0;
    end else begin
      control_in_ex <= opc;
      dest_index    <= rd;
      reg1_data     <= op1;
      reg2_data     <= op2;
      npc           <= npc_in;
      immediate     <= imm;
      ex_valid      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed hazard cases then random
// traffic checked against an array/queue reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic [15:0] npc_in = '0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_index = '0;
  logic [15:0] wb_data = '0;
  logic        stall_out;
  logic [4:0]  control_in_ex;
  logic [4:0]  dest_index;
  logic [15:0] reg1_data;
  logic [15:0] reg2_data;
  logic [15:0] npc;
  logic [6:0]  immediate;
  logic        ex_valid;

  decode_stage dut (
    .clk(clk), .reset(reset), .instr(instr),
    .instr_valid(instr_valid), .npc_in(npc_in),
    .flush(flush), .wb_en(wb_en), .wb_index(wb_index),
    .wb_data(wb_data), .stall_out(stall_out),
    .control_in_ex(control_in_ex), .dest_index(dest_index),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .npc(npc), .immediate(immediate), .ex_valid(ex_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [4:0]  dest;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] npc;
    logic [6:0]  imm;
    logic        v;
  } exo_t;

  exo_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] mregs [32];
  bit          mbusy [32];
  int          pend[$];

  task automatic chk(input string nm, input logic [65:0] act,
                     input logic [65:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd,
                                     input int a, input int b,
                                     input int imm);
    return {op[4:0], rd[4:0], a[4:0], b[4:0], 5'b0, imm[6:0]};
  endfunction

  function automatic logic [15:0] rdval(input int idx, input bit we,
                                        input int wi,
                                        input logic [15:0] wd);
    if (idx == 0) return 16'h0;
    if (we && wi == idx) return wd;
    return mregs[idx];
  endfunction

  function automatic bit src_busy(input int s, input bit we,
                                  input int wi);
    return mbusy[s] && !(we && wi == s);
  endfunction

  // One clock of stimulus plus reference-model step.
  task automatic c(input bit v, input logic [31:0] ins,
                   input logic [15:0] np, input bit fl,
                   input bit we, input int wi,
                   input logic [15:0] wd, input bit rs,
                   output bit stl);
    exo_t e;
    int op, rd, a, b;
    bit u1, u2, w, haz;
    @(posedge clk);
    #3;
    reset = rs;
    instr_valid = v;
    instr = ins;
    npc_in = np;
    flush = fl;
    wb_en = we;
    wb_index = wi[4:0];
    wb_data = wd;
    if (rs) begin
      #1;
      chk("reset_async",
          {control_in_ex, dest_index, reg1_data, reg2_data,
           npc, immediate, ex_valid}, 66'h0);
    end
    @(negedge clk);
    op = int'(ins[31:27]);
    rd = int'(ins[26:22]);
    a  = int'(ins[21:17]);
    b  = int'(ins[16:12]);
    u1 = op != 0;
    u2 = op != 0 && op != 3;
    w  = op != 0 && op < 16;
    if (rs) begin
      for (int k = 0; k < 32; k++) mbusy[k] = 0;
      pend.delete();
    end
    haz = 0;
    if (v && !fl) begin
      if (u1 && src_busy(a, we, wi)) haz = 1;
      if (u2 && src_busy(b, we, wi)) haz = 1;
      if (w && mbusy[rd]) haz = 1;
    end
    chk("stall", {65'h0, stall_out}, {65'h0, haz});
    e = '0;
    if (!rs && v && !fl && !haz) begin
      e.ctl  = ins[31:27];
      e.dest = ins[26:22];
      e.r1   = rdval(a, we, wi, wd);
      e.r2   = rdval(b, we, wi, wd);
      e.npc  = np;
      e.imm  = ins[6:0];
      e.v    = 1'b1;
    end
    expq.push_back(e);
    if (we && wi != 0) mregs[wi] = wd;
    if (we) begin
      mbusy[wi] = 0;
      for (int k = 0; k < pend.size(); k++)
        if (pend[k] == wi) begin
          pend.delete(k);
          break;
        end
    end
    if (e.v && w && rd != 0) begin
      mbusy[rd] = 1;
      pend.push_back(rd);
    end
    stl = haz;
  endtask

  initial begin
    exo_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ex_out",
            {control_in_ex, dest_index, reg1_data, reg2_data,
             npc, immediate, ex_valid}, e);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    int op;
    case ($urandom % 6)
      0: op = 0;
      1: op = 1;
      2: op = 2;
      3: op = 3;
      4: op = 4 + int'($urandom % 12);
      default: op = 16 + int'($urandom % 16);
    endcase
    return mk(op, int'($urandom % 8), int'($urandom % 8),
              int'($urandom % 8), int'($urandom % 128));
  endfunction

  initial begin
    bit s;
    bit holding;
    bit curv, fl, we, rs;
    int wi;
    logic [31:0] cur;
    logic [15:0] curnpc, wd;

    for (int k = 0; k < 32; k++) begin
      mbusy[k] = 0;
      mregs[k] = '0;
    end

    c(0, 0, 0, 0, 0, 0, 0, 1, s);
    c(0, 0, 0, 0, 0, 0, 0, 1, s);
    for (int r = 1; r < 32; r++)
      c(0, 0, 0, 0, 1, r, 16'($urandom), 0, s);
    c(0, 0, 0, 0, 1, 1, 16'd10, 0, s);
    c(0, 0, 0, 0, 1, 2, 16'd3, 0, s);

    c(1, mk(1, 2, 1, 2, 0), 16'd4, 0, 0, 0, 0, 0, s);
    c(0, 0, 0, 0, 0, 0, 0, 0, s);
    chk("sub_ctl", 66'(control_in_ex), 66'd1);
    chk("sub_r1", 66'(reg1_data), 66'd10);
    chk("sub_r2", 66'(reg2_data), 66'd3);
    chk("sub_dest", 66'(dest_index), 66'd2);
    chk("sub_npc", 66'(npc), 66'd4);
    chk("sub_valid", 66'(ex_valid), 66'd1);

    c(1, mk(3, 4, 1, 0, 7), 16'd5, 0, 0, 0, 0, 0, s);
    c(1, mk(2, 5, 4, 1, 0), 16'd6, 0, 0, 0, 0, 0, s);
    chk("raw_stall", 66'(stall_out), 66'd1);
    c(1, mk(2, 5, 4, 1, 0), 16'd6, 0, 0, 0, 0, 0, s);
    chk("raw_bubble", 66'(ex_valid), 66'd0);
    c(1, mk(2, 5, 4, 1, 0), 16'd6, 0, 1, 4, 16'd17, 0, s);
    chk("raw_release", 66'(stall_out), 66'd0);
    c(0, 0, 0, 0, 0, 0, 0, 0, s);
    chk("raw_r1", 66'(reg1_data), 66'd17);
    chk("raw_dest", 66'(dest_index), 66'd5);

    c(1, mk(2, 7, 6, 0, 0), 16'd7, 0, 1, 6, 16'h1234, 0, s);
    chk("byp_stall", 66'(stall_out), 66'd0);
    c(0, 0, 0, 0, 0, 0, 0, 0, s);
    chk("byp_r1", 66'(reg1_data), 66'h1234);
    chk("byp_r2", 66'(reg2_data), 66'd0);

    c(1, mk(2, 8, 5, 1, 0), 16'd8, 1, 0, 0, 0, 0, s);
    chk("flush_stall", 66'(stall_out), 66'd0);
    c(1, mk(2, 9, 8, 0, 0), 16'd9, 0, 0, 0, 0, 0, s);
    chk("flush_nobusy", 66'(stall_out), 66'd0);
    chk("flush_bubble", 66'(ex_valid), 66'd0);

    c(0, 0, 0, 0, 1, 0, 16'hFFFF, 0, s);
    c(1, mk(2, 10, 0, 0, 0), 16'd10, 0, 0, 0, 0, 0, s);
    c(0, 0, 0, 0, 0, 0, 0, 0, s);
    chk("r0_read", 66'(reg1_data), 66'd0);

    c(0, 0, 0, 0, 0, 0, 0, 1, s);
    c(1, mk(2, 3, 2, 1, 0), 16'd11, 0, 0, 0, 0, 0, s);
    chk("post_reset_stall", 66'(stall_out), 66'd0);
    c(0, 0, 0, 0, 0, 0, 0, 0, s);
    chk("post_reset_valid", 66'(ex_valid), 66'd1);
    chk("post_reset_dest", 66'(dest_index), 66'd3);

    holding = 0;
    cur = '0;
    curnpc = '0;
    curv = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!holding) begin
        curv = ($urandom % 4) != 0;
        cur = rand_instr();
        curnpc = 16'($urandom);
      end
      fl = ($urandom % 12) == 0;
      we = 0;
      wi = 0;
      wd = 16'($urandom);
      rs = ($urandom % 400) == 0;
      if (pend.size() > 0 && ($urandom % 3) == 0) begin
        we = 1;
        wi = pend[0];
      end else if (($urandom % 8) == 0) begin
        wi = int'($urandom % 8);
        we = !mbusy[wi];
      end
      if (rs) begin
        we = 0;
        curv = 0;
      end
      c(curv, cur, curnpc, fl, we, wi, wd, rs, s);
      holding = curv && s;
    end

    c(0, 0, 0, 0, 0, 0, 0, 0, s);
    @(posedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the pipelined CPU. Splits each fetched 32-bit instruction into the opcode, destination index, source operands, next-PC and 7-bit immediate that feed the Execute stage. Contains the 32×16-bit register file (written back from the Writeback stage) and a per-register busy scoreboard that interlocks read-after-write and write-after-write hazards. All Execute-facing outputs come from one registered ID/EX pipeline register.

## Interface
- NUM_REGS, 32, register file depth; index width fixed at 5
- DATA_W, 16, register and NPC width

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears pipeline register and scoreboard
- instr  in  32  fetched instruction: [31:27] opcode, [26:22] rd, [21:17] rs1, [16:12] rs2, [6:0] imm7
- instr_valid  in  1  instr/npc_in valid this cycle
- npc_in  in  16  PC+1 of instr
- flush  in  1  branch taken in Execute; discard the instruction being decoded
- wb_en  in  1  writeback write enable
- wb_index  in  5  writeback destination
- wb_data  in  16  writeback data
- stall_out  out  1  combinational; fetch must hold instr/npc_in
- control_in_ex  out  5  opcode to Execute (control_in)
- dest_index  out  5  destination register to Execute
- reg1_data  out  16  rs1 operand
- reg2_data  out  16  rs2 operand
- npc  out  16  NPC to Execute
- immediate  out  7  imm7 to Execute
- ex_valid  out  1  ID/EX register holds a real instruction

## Operation
- Opcode classes: 00000 NOP (no reads, no write); 00011 ADDI (reads rs1, writes rd); other 00001–01111 (SUB 00001, ADD 00010, …) read rs1 and rs2, write rd; 10000–11111 read rs1 and rs2, no write.
- Register file: R0 reads 0; writes to R0 ignored. Write on rising clk when wb_en. Read bypass: if wb_en and wb_index equals a nonzero source index, that operand reads wb_data in the same cycle.
- Scoreboard: 32 busy bits, busy[0] always 0. Set busy[rd] when a writing instruction issues with rd≠0; clear busy[wb_index] on wb_en. Same register set and cleared in one cycle: set wins.
- Hazard = instr_valid and not flush and (any used source busy, or writing instruction with busy[rd]). A source being cleared by wb_en this cycle is not busy (bypass supplies it).
- stall_out = hazard.
- ID/EX update each rising clk, priority order: reset → all outputs 0; flush → bubble; hazard → bubble; instr_valid → latch decoded fields, ex_valid=1; otherwise bubble.
- Bubble: control_in_ex=00000, dest_index=0, reg1_data=0, reg2_data=0, npc=0, immediate=0, ex_valid=0. Bubbles never set busy bits.
- Flush has priority over hazard; flushed instruction never sets busy and stall_out is 0 that cycle.

## Timing
- Reset (async, any time): every output register 0, all busy bits 0, stall_out 0; register file contents undefined after reset (bench writes before reading). Reset mid-stall drops the stalled instruction.
- Decode latency 1 cycle: instruction presented in cycle N appears on Execute outputs after edge N.
- Dependent back-to-back instruction stalls until the cycle in which wb_en writes the producing register; it issues at the end of that cycle with the bypassed value.
- stall_out is combinational from instr, instr_valid, flush, wb_en, wb_index and the scoreboard; it carries no register.
- Fetch must hold instr/npc_in stable while stall_out=1.

## Test plan
- Reset mid-operation with busy[2] set -> all outputs 0, busy cleared; next ADD R3,R2,R1 issues without stall.
- Write R1=10, R2=3 via wb; issue SUB R2,R1,R2 (npc_in=4) -> next cycle control_in_ex=00001, reg1_data=10, reg2_data=3, dest_index=2, npc=4, ex_valid=1.
- ADDI R4,R1,imm7=7 followed by ADD R5,R4,R1 -> stall_out=1 and bubbles until wb_en R4=17; ADD issues that cycle with reg1_data=17.
- Same-cycle wb_en R6=0x1234 and decode of ADD R7,R6,R0 -> reg1_data=0x1234, reg2_data=0, no stall.
- flush asserted while a hazard is pending -> bubble, stall_out=0, busy[rd] not set.
- wb_en to R0 with data 0xFFFF, then read R0 -> reg1_data=0.
